// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// -----------------------------------------------------------------------------
// Round-robin transmit scheduler in front of the memory-mapped UART controller.
// Several byte producers offer bytes on a valid/ready interface. One byte is
// accepted at a time. Each accepted byte is sent to the controller in four
// steps: a data register write, a TX-enable control write, a short settle
// delay, then repeated polling of the busy flag until it clears.
//
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN
//   When defined, a 16-bit poll counter aborts a stuck poll. The abort happens
//   after TIMEOUT_CYCLES poll cycles and pulses err. When not defined, POLL
//   waits indefinitely and err is tied low.
//
// Ports
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ-1:0]   per-requester byte valid
//   req_data   in   [8*NUM_REQ-1:0] byte of requester i at [8i+7:8i]
//   req_ready  out  [NUM_REQ-1:0]   one-hot accept strobe (IDLE only)
//   grant_id   out  [2:0]           requester whose byte is in flight
//   done       out  one-cycle pulse when the poll sees busy clear
//   err        out  one-cycle poll-timeout pulse (0 without the macro)
//   mem_addr   out  [31:0] controller register address
//   mem_wdata  out  [31:0] controller write data
//   mem_we     out  write strobe
//   mem_re     out  read strobe
//   mem_rdata  in   [31:0] combinational read data, bit 0 = TX busy at +0x4
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int          NUM_REQ        = 3,
    parameter logic [31:0] UART_BASE_ADDR = 32'h4000_0000,
    parameter int          SETTLE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [2:0]             grant_id,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic                   mem_we,
    output logic                   mem_re,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_CTRL = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_POLL    = 3'd4
    } state_t;

    localparam logic [3:0]  NUM_REQ_W   = 4'(NUM_REQ);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] ADDR_DATA   = UART_BASE_ADDR;
    localparam logic [31:0] ADDR_CTRL   = UART_BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] CTRL_TX_EN  = 32'h0000_0002;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [2:0]  rr_ptr_r;
    logic [7:0]  byte_q_r;
    logic [15:0] cnt_r;

    logic [7:0]  valid_pad_s;
    logic [63:0] data_pad_s;
    logic        any_s;
    logic [2:0]  win_s;
    logic [3:0]  win_nxt_s;
    logic [7:0]  win_byte_s;
    logic [7:0]  ready_pad_s;
    logic        accept_s;
    logic        unused_s;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic [15:0] poll_cnt_r;
    assign unused_s = ^mem_rdata[31:1];
`else
    // TMO_LAST is folded in here only so the disabled build keeps the parameter referenced.
    assign unused_s = ^{mem_rdata[31:1], TMO_LAST};
`endif

    // Round-robin winner search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        valid_pad_s              = 8'd0;
        valid_pad_s[NUM_REQ-1:0] = req_valid;
        data_pad_s                  = 64'd0;
        data_pad_s[8*NUM_REQ-1:0]   = req_data;
        any_s = 1'b0;
        win_s = 3'd0;
        // Scan from the farthest offset down so the nearest valid one wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            logic [3:0] idx;
            idx = {1'b0, rr_ptr_r} + 4'(i);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end else begin
                idx = idx;
            end
            if (valid_pad_s[idx[2:0]]) begin
                any_s = 1'b1;
                win_s = idx[2:0];
            end else begin
                any_s = any_s;
            end
        end
        win_nxt_s = {1'b0, win_s} + 4'd1;
        if (win_nxt_s >= NUM_REQ_W) begin
            win_nxt_s = 4'd0;
        end else begin
            win_nxt_s = win_nxt_s;
        end
        win_byte_s  = data_pad_s[{win_s, 3'b000} +: 8];
        ready_pad_s = 8'd1 << win_s;
    end

    // Next-state and output decode; mem_* depend only on state and registers.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        req_ready   = '0;
        done        = 1'b0;
        err         = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = 32'd0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (any_s && rst_n) begin
                    accept_s    = 1'b1;
                    req_ready   = ready_pad_s[NUM_REQ-1:0];
                    state_nxt_s = ST_WR_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                mem_we      = 1'b1;
                mem_addr    = ADDR_DATA;
                mem_wdata   = {24'd0, byte_q_r};
                state_nxt_s = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                mem_we      = 1'b1;
                mem_addr    = ADDR_CTRL;
                mem_wdata   = CTRL_TX_EN;
                state_nxt_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_POLL;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_POLL: begin
                mem_re   = 1'b1;
                mem_addr = ADDR_CTRL;
                if (!mem_rdata[0]) begin
                    done        = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
`ifdef UART_TX_SCHED_TIMEOUT_EN
                    if (poll_cnt_r == TMO_LAST) begin
                        err         = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_POLL;
                    end
`else
                    state_nxt_s = ST_POLL;
`endif
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant bookkeeping: latch byte, grant index and advance the rotation pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q_r <= 8'd0;
            grant_id <= 3'd0;
            rr_ptr_r <= 3'd0;
        end else if (accept_s) begin
            byte_q_r <= win_byte_s;
            grant_id <= win_s;
            rr_ptr_r <= win_nxt_s[2:0];
        end
    end

    // Settle delay counter: cleared by the control write, counts through SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else begin
            case (state_r)
                ST_WR_CTRL: cnt_r <= 16'd0;
                ST_SETTLE:  cnt_r <= cnt_r + 16'd1;
                default:    cnt_r <= cnt_r;
            endcase
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    // Poll counter: zero on POLL entry, +1 per POLL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_r <= 16'd0;
        end else if (state_r == ST_POLL) begin
            poll_cnt_r <= poll_cnt_r + 16'd1;
        end else begin
            poll_cnt_r <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched: a 3-requester instance and a
// 1-requester instance, with a settable busy flag standing in for the UART.
module tb_uart_tx_sched;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] CTRL = 32'h4000_0004;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [2:0]  grant_id;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [0:0]  v1;
    logic [7:0]  d1;
    logic [0:0]  ready1;
    logic [2:0]  grant1;
    logic        done1;
    logic        err1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        we1;
    logic        re1;
    logic [31:0] rdata1;

    int n_assert = 0;
    int n_fail   = 0;

    assign mem_rdata = {31'd0, busy};
    assign rdata1    = 32'd0;

    uart_tx_sched #(.NUM_REQ(3)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .grant_id(grant_id), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    uart_tx_sched #(.NUM_REQ(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_data(d1), .req_ready(ready1),
        .grant_id(grant1), .done(done1), .err(err1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_we(we1),
        .mem_re(re1), .mem_rdata(rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic re,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic dn);
        chk({tag, "_we"},    32'(mem_we),   32'(we));
        chk({tag, "_re"},    32'(mem_re),   32'(re));
        chk({tag, "_addr"},  mem_addr,      addr);
        chk({tag, "_wdata"}, mem_wdata,     wdata);
        chk({tag, "_done"},  32'(done),     32'(dn));
        chk({tag, "_err"},   32'(err),      32'd0);
    endtask

    // Called in the IDLE accept cycle; returns in the done cycle.
    task automatic do_byte(input logic [2:0] g, input logic [7:0] b, input int busy_polls);
        logic [2:0] onehot;
        onehot = 3'b001 << g;
        #1;
        chk("t0_ready", 32'(req_ready), 32'(onehot));
        chk_bus("t0", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        busy = 1'b1;
        chk("t1_grant", 32'(grant_id), 32'(g));
        chk("t1_ready", 32'(req_ready), 32'd0);
        chk_bus("t1", 1'b1, 1'b0, BASE, {24'd0, b}, 1'b0);
        step();
        chk_bus("t2", 1'b1, 1'b0, CTRL, 32'h2, 1'b0);
        step();
        chk_bus("t3", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk_bus("t4", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int p = 0; p < busy_polls; p++) begin
            step();
            chk_bus("poll_busy", 1'b0, 1'b1, CTRL, 32'd0, 1'b0);
        end
        step();
        busy = 1'b0;
        #1;
        chk_bus("poll_done", 1'b0, 1'b1, CTRL, 32'd0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        busy      = 1'b0;
        req_valid = 3'b001;
        req_data  = 24'd0;
        v1        = 1'b0;
        d1        = 8'd0;
        #12;
        // Reset state, with a valid request present.
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk_bus("rst", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("rst_ready1", 32'(ready1), 32'd0);

        // Single byte 0x41 from requester 0, busy clear at the first poll.
        step();
        rst_n     = 1'b1;
        req_valid = 3'b001;
        req_data  = {8'h00, 8'h00, 8'h41};
        do_byte(3'd0, 8'h41, 0);
        step();
        req_valid = 3'b000;
        #1;
        chk("idle_ready", 32'(req_ready), 32'd0);
        chk_bus("idle", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Contention: rr_ptr is 1, so rotation runs 1,2,0,1 back to back.
        step();
        req_valid = 3'b111;
        req_data  = {8'hC2, 8'hB1, 8'hA0};
        do_byte(3'd1, 8'hB1, 2);
        step();
        do_byte(3'd2, 8'hC2, 1);
        step();
        do_byte(3'd0, 8'hA0, 0);
        step();
        do_byte(3'd1, 8'hB1, 0);

        // Pointer wrap: rr_ptr=2, valids 011 -> 0 then 1.
        step();
        req_valid = 3'b011;
        req_data  = {8'h33, 8'h22, 8'h11};
        do_byte(3'd0, 8'h11, 0);
        step();
        do_byte(3'd1, 8'h22, 0);
        step();
        req_valid = 3'b000;
        #1;
        chk("hold_ready", 32'(req_ready), 32'd0);
        step();
        chk("hold_grant", 32'(grant_id), 32'd1);

        // Reset in the middle of POLL with busy set.
        req_valid = 3'b100;
        req_data  = {8'hC2, 8'h00, 8'h5A};
        #1;
        chk("mr_ready", 32'(req_ready), 32'd4);
        step();
        req_valid = 3'b000;
        busy      = 1'b1;
        chk("mr_grant", 32'(grant_id), 32'd2);
        step();
        step();
        step();
        step();
        chk_bus("mr_poll", 1'b0, 1'b1, CTRL, 32'd0, 1'b0);
        rst_n     = 1'b0;
        req_valid = 3'b001;
        #1;
        chk_bus("mr_rst", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        chk("mr_rst_ready", 32'(req_ready), 32'd0);
        chk("mr_rst_grant", 32'(grant_id), 32'd0);
        step();
        chk_bus("mr_held", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        rst_n = 1'b1;
        busy  = 1'b0;
        do_byte(3'd0, 8'h5A, 0);

        // Busy stuck for 40 polls: no err, keeps polling, then done.
        step();
        req_valid = 3'b010;
        req_data  = {8'h00, 8'h7E, 8'h00};
        do_byte(3'd1, 8'h7E, 40);
        step();
        req_valid = 3'b000;

        // Single-requester instance: valid held, accept right after each done.
        v1 = 1'b1;
        d1 = 8'h55;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("n1_ready", 32'(ready1), 32'd1);
            step();
            chk("n1_grant", 32'(grant1), 32'd0);
            chk("n1_we", 32'(we1), 32'd1);
            chk("n1_wdata", wdata1, 32'h55);
            chk("n1_addr", addr1, BASE);
            step();
            step();
            step();
            step();
            chk("n1_re", 32'(re1), 32'd1);
            chk("n1_done", 32'(done1), 32'd1);
            chk("n1_err", 32'(err1), 32'd0);
            step();
        end
        v1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin transmit scheduler that shares the single UART TX channel of the memory-mapped UART controller among several on-chip byte producers (CPU shim, debug logger, boot monitor). It owns the controller's register port and sequences each byte as a data write, a TX-enable write, a settle delay and a busy poll, so producers see only a simple valid/ready byte interface.

## Interface
- NUM_REQ, 3: number of requesters; 1..8.
- UART_BASE_ADDR, 32'h40000000: base of the UART register window; low 8 bits zero.
- SETTLE_CYCLES, 2: idle cycles between the TX-enable write and the first busy poll; ≥2.
- TIMEOUT_CYCLES, 65535: poll cycles before abort; used only with the timeout macro; 16-bit.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe; the byte transfers when valid&ready.
- grant_id  out  3  index of the requester whose byte is in flight.
- done  out  1  one-cycle pulse when the in-flight byte's poll sees busy clear.
- err  out  1  one-cycle timeout pulse; constant 0 without the timeout macro.
- mem_addr  out  32  register address to the UART controller.
- mem_wdata  out  32  write data.
- mem_we  out  1  write strobe; one cycle per write.
- mem_re  out  1  read strobe.
- mem_rdata  in  32  combinational read data from the controller; bit 0 is TX busy at offset 0x4.

## Operation
- States: IDLE, WR_DATA, WR_CTRL, SETTLE, POLL.
- IDLE: the bus is quiet. If any req_valid is set, the winner is the first set bit at or after rr_ptr, wrapping modulo NUM_REQ. req_ready[winner]=1 in the same cycle. req_data is latched into byte_q, grant_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, and the state moves to WR_DATA.
- WR_DATA: mem_we=1, mem_addr=BASE+0x0, mem_wdata={24'b0,byte_q}. Lasts 1 cycle, then WR_CTRL.
- WR_CTRL: mem_we=1, mem_addr=BASE+0x4, mem_wdata=32'h2 (bit 1 = TX enable). Lasts 1 cycle, then SETTLE with cnt<=0.
- SETTLE: the bus is quiet. cnt increments each cycle. After SETTLE_CYCLES cycles the state moves to POLL. This covers the controller's registered enable and busy rise.
- POLL: mem_re=1, mem_addr=BASE+0x4 every cycle. If mem_rdata[0]==0, done=1 for this cycle and the next state is IDLE. Otherwise the state stays in POLL.
- Outside active states, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- mem_* outputs decode only from state and registers. There is no combinational path from mem_rdata to mem_*. The only mem_rdata path is into next-state logic.
- A requester that drops valid before being granted loses nothing. Arbitration re-evaluates every IDLE cycle.
- NUM_REQ=1: always grants index 0; rr_ptr stays 0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, byte_q=0, cnt=0, and all outputs 0.
- Accept cycle T0 → data write T1 → control write T2 → SETTLE T3..T2+SETTLE_CYCLES → first poll at T3+SETTLE_CYCLES.
- With defaults and an idle UART, the earliest done is T5 (busy already clear). Normally done comes after a full UART frame.
- Earliest next accept: the cycle after done. This gives at most one byte in flight, so there is no FIFO.
- Simultaneous valids from all requesters: they are served in strict rotation starting from rr_ptr. Each gets exactly one byte per rotation.
- Reset asserted mid-sequence: mem_we, mem_re and req_ready drop asynchronously. The in-flight byte is discarded. No done or err pulse is issued.
- Back-to-back bytes from one sole requester: accepted every sequence with no idle cycle beyond the IDLE accept cycle.

## Configuration
- UART_TX_SCHED_TIMEOUT_EN defined:
  - A 16-bit poll counter clears on entry to POLL and increments each POLL cycle.
  - If busy is still set when the count reaches TIMEOUT_CYCLES-1, the block pulses err=1 for that cycle, does not pulse done, and returns to IDLE.
  - grant_id holds the offender until the next grant.
- Not defined: the counter is absent, POLL waits indefinitely, and err is tied 0.

## Test plan
- Single byte: req_valid=3'b001, req_data[7:0]=8'h41, UART idle → req_ready=001 at T0; T1 write 0x40000000/0x41; T2 write 0x40000004/0x2; first poll at T5; done after the 0x41 frame appears on uart_tx.
- Contention: all three valid with bytes 0xA0/0xB1/0xC2 held → grant order 0,1,2,0 and req_ready one-hot each time; TX line carries A0 B1 C2 A0.
- Pointer wrap: rr_ptr=2 (after granting 1), valids 3'b011 → grants 0 next, then 1.
- Reset mid-POLL: pulse rst_n low while busy=1 → all outputs 0 immediately, no done, and the state is IDLE when rst_n releases.
- Busy stuck at 1 with TIMEOUT_CYCLES=16 and macro defined → err pulses exactly 16 poll cycles after POLL entry, done stays 0, and the next requester is granted. Without the macro → remains in POLL, err=0.
- NUM_REQ=1, valid held with data 0x55 → consecutive sequences, each accept exactly one cycle after the previous done.
